// File: rtl/biquad_cascade_scheduler.sv
// rtl/biquad_cascade_scheduler.sv - shared-MAC sequencer for cascaded stereo Q2.14 biquads
// Optional build macro: BIQUAD_SATURATE_EN (saturating writeback instead of wrap).
module biquad_cascade_scheduler #(
  parameter int NUM_STAGES = 3,
  parameter int MAC_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        l_r_clk,
  input  logic [15:0] sample_in,
  input  logic        coef_we,
  input  logic [4:0]  coef_addr,
  input  logic [15:0] coef_wdata,
  input  logic        coef_commit,
  output logic [15:0] mac_coef,
  output logic [15:0] mac_data,
  output logic        mac_ce,
  output logic        mac_clr,
  input  logic [31:0] mac_result,
  output logic        out_valid,
  output logic        out_chan,
  output logic [15:0] out_sample,
  output logic        busy,
  output logic        overrun
);
  localparam int NCOEF = NUM_STAGES * 5;
  localparam int CW    = $clog2(NCOEF);
  localparam int SW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int DW    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_ISSUE, S_DRAIN, S_WB, S_OUT} state_t;

  state_t          state_q;
  logic            sync1_q, sync2_q, lr_edge;
  logic            chan_q, pending_q, do_copy;
  logic [SW-1:0]   stage_q;
  logic [2:0]      tap_q, issue_tap;
  logic [DW-1:0]   drain_q;
  logic [15:0]     x_q;
  logic [15:0]     shadow_q [NCOEF];
  logic [15:0]     active_q [NCOEF];
  logic [15:0]     x1_q [2][NUM_STAGES];
  logic [15:0]     x2_q [2][NUM_STAGES];
  logic [15:0]     y1_q [2][NUM_STAGES];
  logic [15:0]     y2_q [2][NUM_STAGES];
  logic [15:0]     mac_coef_q, mac_data_q, out_sample_q;
  logic            mac_ce_q, mac_clr_q, out_valid_q, out_chan_q;
  logic [15:0]     op_coef_d, op_data_d, wb_v_d;

  assign lr_edge    = sync1_q ^ sync2_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = lr_edge && busy;
  assign mac_coef   = mac_coef_q;
  assign mac_data   = mac_data_q;
  assign mac_ce     = mac_ce_q;
  assign mac_clr    = mac_clr_q;
  assign out_valid  = out_valid_q;
  assign out_chan   = out_chan_q;
  assign out_sample = out_sample_q;

  // Bank swap only at sample boundaries so one sample never sees two banks.
  assign do_copy = (state_q == S_IDLE && coef_commit && !lr_edge) ||
                   (state_q == S_OUT && (pending_q || coef_commit));

  // Two-flop synchroniser on the L/R select; each toggle announces a sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= l_r_clk;
      sync2_q <= sync1_q;
    end
  end

  // Shadow bank writes, deferred commit flag and shadow->active copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= (i % 5 == 0) ? 16'h4000 : 16'h0000;
        active_q[i] <= (i % 5 == 0) ? 16'h4000 : 16'h0000;
      end
      pending_q <= 1'b0;
    end else begin
      if (coef_we && ({1'b0, coef_addr} < 6'(NCOEF)))
        shadow_q[CW'(coef_addr)] <= coef_wdata;
      if (do_copy) begin
        for (int i = 0; i < NCOEF; i++) active_q[i] <= shadow_q[i];
        pending_q <= 1'b0;
      end else if (coef_commit) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Operands for the tap about to be issued; feedback taps use negated a1/a2.
  always_comb begin
    issue_tap = (state_q == S_CLR) ? 3'd0 : tap_q + 3'd1;
    op_coef_d = active_q[CW'(8'(stage_q) * 8'd5 + 8'(issue_tap))];
    op_data_d = 16'h0000;
    case (issue_tap)
      3'd0: op_data_d = x_q;
      3'd1: op_data_d = x1_q[chan_q][stage_q];
      3'd2: op_data_d = x2_q[chan_q][stage_q];
      3'd3: begin
        op_data_d = y1_q[chan_q][stage_q];
        op_coef_d = 16'h0000 - op_coef_d;
      end
      3'd4: begin
        op_data_d = y2_q[chan_q][stage_q];
        op_coef_d = 16'h0000 - op_coef_d;
      end
      default: op_coef_d = 16'h0000;
    endcase
  end

`ifdef BIQUAD_SATURATE_EN
  // Round Q4.28 to Q2.14, clamping when the integer bits or the rounding overflow.
  always_comb begin
    wb_v_d = mac_result[29:14] + 16'(mac_result[13]);
    if ((mac_result[31:29] != 3'b000 && mac_result[31:29] != 3'b111) ||
        (mac_result[29:14] == 16'h7FFF && mac_result[13]))
      wb_v_d = mac_result[31] ? 16'h8000 : 16'h7FFF;
  end
`else
  logic unused_msbs;
  assign unused_msbs = ^mac_result[31:30];
  // Round Q4.28 to Q2.14, wrapping on overflow.
  always_comb begin
    wb_v_d = mac_result[29:14] + 16'(mac_result[13]);
  end
`endif

  // Main sequencer: one stage = CLR, five taps, MAC drain, writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      chan_q       <= 1'b0;
      stage_q      <= '0;
      tap_q        <= 3'd0;
      drain_q      <= '0;
      x_q          <= 16'h0000;
      mac_coef_q   <= 16'h0000;
      mac_data_q   <= 16'h0000;
      mac_ce_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_chan_q   <= 1'b0;
      out_sample_q <= 16'h0000;
      for (int c = 0; c < 2; c++) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          x1_q[c][s] <= 16'h0000;
          x2_q[c][s] <= 16'h0000;
          y1_q[c][s] <= 16'h0000;
          y2_q[c][s] <= 16'h0000;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lr_edge) begin
            x_q     <= sample_in;
            chan_q  <= sync1_q;
            stage_q <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          mac_clr_q <= 1'b1;
          state_q   <= S_CLR;
        end
        S_CLR: begin
          mac_clr_q  <= 1'b0;
          mac_ce_q   <= 1'b1;
          mac_coef_q <= op_coef_d;
          mac_data_q <= op_data_d;
          tap_q      <= 3'd0;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (tap_q == 3'd4) begin
            mac_ce_q   <= 1'b0;
            mac_coef_q <= 16'h0000;
            mac_data_q <= 16'h0000;
            drain_q    <= '0;
            state_q    <= S_DRAIN;
          end else begin
            mac_coef_q <= op_coef_d;
            mac_data_q <= op_data_d;
            tap_q      <= tap_q + 3'd1;
          end
        end
        S_DRAIN: begin
          if (drain_q == DW'(MAC_LAT - 1)) state_q <= S_WB;
          else drain_q <= drain_q + DW'(1);
        end
        S_WB: begin
          x2_q[chan_q][stage_q] <= x1_q[chan_q][stage_q];
          x1_q[chan_q][stage_q] <= x_q;
          y2_q[chan_q][stage_q] <= y1_q[chan_q][stage_q];
          y1_q[chan_q][stage_q] <= wb_v_d;
          x_q <= wb_v_d;
          if (stage_q == SW'(NUM_STAGES - 1)) begin
            out_valid_q  <= 1'b1;
            out_sample_q <= wb_v_d;
            out_chan_q   <= chan_q;
            state_q      <= S_OUT;
          end else begin
            stage_q   <= stage_q + SW'(1);
            mac_clr_q <= 1'b1;
            state_q   <= S_CLR;
          end
        end
        S_OUT: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_biquad_cascade_scheduler.sv
// tb/tb_biquad_cascade_scheduler.sv - self-checking bench for biquad_cascade_scheduler
module tb_biquad_cascade_scheduler;
  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        reset, l_r_clk, coef_we, coef_commit;
  logic [15:0] sample_in, coef_wdata;
  logic [4:0]  coef_addr;
  logic [15:0] mac_coef, mac_data, out_sample;
  logic        mac_ce, mac_clr, out_valid, out_chan, busy, overrun;
  logic [31:0] mac_result;
  logic signed [31:0] acc_q;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        chan;
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;

  logic [15:0] m_shadow [NS*5];
  logic [15:0] m_active [NS*5];
  logic [15:0] m_x1 [2][NS];
  logic [15:0] m_x2 [2][NS];
  logic [15:0] m_y1 [2][NS];
  logic [15:0] m_y2 [2][NS];

  always #5 clk = ~clk;

  biquad_cascade_scheduler #(.NUM_STAGES(NS), .MAC_LAT(1)) dut (
    .clk(clk), .reset(reset), .l_r_clk(l_r_clk), .sample_in(sample_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .mac_coef(mac_coef), .mac_data(mac_data),
    .mac_ce(mac_ce), .mac_clr(mac_clr), .mac_result(mac_result),
    .out_valid(out_valid), .out_chan(out_chan), .out_sample(out_sample),
    .busy(busy), .overrun(overrun)
  );

  // Accumulating DSP slice with one cycle of latency.
  always @(posedge clk) begin
    if (reset || mac_clr) acc_q <= 32'sd0;
    else if (mac_ce) acc_q <= acc_q + $signed(mac_coef) * $signed(mac_data);
  end
  assign mac_result = acc_q;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic int mul(input logic [15:0] a, input logic [15:0] b);
    return int'($signed(a)) * int'($signed(b));
  endfunction

  function automatic logic [15:0] neg16(input logic [15:0] a);
    logic [15:0] r;
    r = 16'h0000 - a;
    return r;
  endfunction

  function automatic logic [15:0] m_round(input int acc);
    longint r;
    r = (longint'(acc) + 64'sd8192) >>> 14;
`ifdef BIQUAD_SATURATE_EN
    if (r > 64'sd32767) return 16'h7FFF;
    if (r < -64'sd32768) return 16'h8000;
`endif
    return 16'(r);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS*5; i++) begin
      m_shadow[i] = (i % 5 == 0) ? 16'h4000 : 16'h0000;
      m_active[i] = m_shadow[i];
    end
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < NS; s++) begin
        m_x1[c][s] = 0; m_x2[c][s] = 0; m_y1[c][s] = 0; m_y2[c][s] = 0;
      end
  endtask

  task automatic m_commit();
    for (int i = 0; i < NS*5; i++) m_active[i] = m_shadow[i];
  endtask

  task automatic m_run(input logic c, input logic [15:0] xin, output logic [15:0] y);
    logic [15:0] x, v;
    int acc;
    int ci;
    ci = c ? 1 : 0;
    x = xin;
    for (int s = 0; s < NS; s++) begin
      acc = mul(m_active[s*5], x) + mul(m_active[s*5+1], m_x1[ci][s]) +
            mul(m_active[s*5+2], m_x2[ci][s]) + mul(neg16(m_active[s*5+3]), m_y1[ci][s]) +
            mul(neg16(m_active[s*5+4]), m_y2[ci][s]);
      v = m_round(acc);
      m_x2[ci][s] = m_x1[ci][s]; m_x1[ci][s] = x;
      m_y2[ci][s] = m_y1[ci][s]; m_y1[ci][s] = v;
      x = v;
    end
    y = x;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; l_r_clk = 1'b0; sample_in = 0;
    coef_we = 1'b0; coef_commit = 1'b0; coef_addr = 0; coef_wdata = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  task automatic wr_coef(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(negedge clk);
    coef_we = 1'b0;
    if (a < 5'(NS*5)) m_shadow[a] = d;
  endtask

  task automatic commit_idle();
    @(negedge clk);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    m_commit();
  endtask

  task automatic raw_send(input logic c, input logic [15:0] s, input string nm,
                          input bit use_exp, input logic [15:0] req);
    int lat;
    logic [15:0] got, mexp;
    logic gotc;
    m_run(c, s, mexp);
    if (!use_exp) req = mexp;
    @(negedge clk);
    sample_in = s; l_r_clk = c;
    @(posedge clk);
    lat = -1; got = 0; gotc = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; got = out_sample; gotc = out_chan; end
    end
    check({nm, "_lat"}, lat, 26);
    check({nm, "_out"}, got, req);
    check({nm, "_chan"}, gotc, c);
  endtask

  task automatic send(input logic c, input logic [15:0] s, input string nm,
                      input bit use_exp, input logic [15:0] req);
    if (l_r_clk == c) raw_send(!c, 16'h0000, {nm, "_pre"}, 1'b0, 16'h0000);
    raw_send(c, s, nm, use_exp, req);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t3 [4];
    vec_t t4 [7];
    int nv, nov, lat;
    logic [15:0] got, mexp, t6_exp;
    logic gotc;

    t3[0] = '{1'b0, 16'h4000, 16'h0000};
    t3[1] = '{1'b1, 16'h0000, 16'h0000};
    t3[2] = '{1'b0, 16'h0000, 16'h4000};
    t3[3] = '{1'b1, 16'h0000, 16'h0000};
    t4[0] = '{1'b0, 16'h4000, 16'h4000};
    t4[1] = '{1'b1, 16'h0000, 16'h0000};
    t4[2] = '{1'b0, 16'h0000, 16'h2000};
    t4[3] = '{1'b1, 16'h0000, 16'h0000};
    t4[4] = '{1'b0, 16'h0000, 16'h1000};
    t4[5] = '{1'b1, 16'h0000, 16'h0000};
    t4[6] = '{1'b0, 16'h0000, 16'h0800};
`ifdef BIQUAD_SATURATE_EN
    t6_exp = 16'h7FFF;
`else
    t6_exp = 16'hFFFC;
`endif

    reset = 1'b1; l_r_clk = 1'b0; sample_in = 0;
    coef_we = 1'b0; coef_commit = 1'b0; coef_addr = 0; coef_wdata = 0;
    do_reset();
    check("rst_mac", {mac_coef, mac_data, mac_ce, mac_clr}, 0);
    check("rst_out", {out_valid, out_chan, out_sample}, 0);
    check("rst_busy", {busy, overrun}, 0);

    // Passthrough with reset coefficients and the 26-cycle latency.
    send(1'b0, 16'h1234, "t1", 1'b1, 16'h1234);

    // Halving gain after an idle commit.
    wr_coef(5'd0, 16'h2000);
    commit_idle();
    send(1'b0, 16'h4000, "t2", 1'b1, 16'h2000);

    // Pure one-sample delay per channel.
    do_reset();
    wr_coef(5'd0, 16'h0000);
    wr_coef(5'd1, 16'h4000);
    commit_idle();
    for (int i = 0; i < 4; i++) send(t3[i].chan, t3[i].x, $sformatf("t3_%0d", i), 1'b1, t3[i].y);

    // First-order recursion y = x + 0.5*y1.
    do_reset();
    wr_coef(5'd3, 16'hE000);
    commit_idle();
    for (int i = 0; i < 7; i++) send(t4[i].chan, t4[i].x, $sformatf("t4_%0d", i), 1'b1, t4[i].y);

    // Overrun while busy, plus a commit that must wait for the sample boundary.
    do_reset();
    @(negedge clk);
    sample_in = 16'h1111; l_r_clk = 1'b1;
    m_run(1'b1, 16'h1111, mexp);
    @(posedge clk);
    nv = 0; nov = 0; lat = -1; got = 0; gotc = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      case (k)
        4: begin coef_we = 1'b1; coef_addr = 5'd0; coef_wdata = 16'h2000; end
        5: begin coef_we = 1'b0; coef_commit = 1'b1; end
        6: coef_commit = 1'b0;
        10: begin sample_in = 16'h2222; l_r_clk = 1'b0; end
        default: ;
      endcase
      @(posedge clk); #1;
      if (k == 10) check("t5_overrun_pulse", overrun, 1);
      if (overrun) nov++;
      if (out_valid) begin nv++; lat = k; got = out_sample; gotc = out_chan; end
    end
    m_shadow[0] = 16'h2000;
    m_commit();
    check("t5_overrun_count", nov, 1);
    check("t5_valid_count", nv, 1);
    check("t5_lat", lat, 26);
    check("t5_out", got, 16'h1111);
    check("t5_out_model", got, mexp);
    check("t5_chan", gotc, 1);
    check("t5_idle", busy, 0);
    send(1'b0, 16'h4000, "t5_newbank", 1'b1, 16'h2000);

    // Overflowing product: saturates or wraps depending on the build.
    do_reset();
    wr_coef(5'd0, 16'h7FFF);
    commit_idle();
    send(1'b0, 16'h7FFF, "t6", 1'b1, t6_exp);

    // Reset mid-computation aborts and restores passthrough coefficients.
    wr_coef(5'd0, 16'h2000);
    commit_idle();
    @(negedge clk);
    sample_in = 16'h5555; l_r_clk = 1'b1;
    repeat (12) @(posedge clk);
    do_reset();
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) nv++;
    end
    check("abort_no_valid", nv, 0);
    check("abort_idle", busy, 0);
    send(1'b0, 16'h1234, "abort_bank", 1'b1, 16'h1234);

    // Random coefficients and samples against the reference model.
    do_reset();
    for (int a = 0; a < NS*5; a++) wr_coef(5'(a), 16'($urandom_range(0, 16'h3FFF)) - 16'h2000);
    wr_coef(5'd20, 16'h7777);
    commit_idle();
    for (int i = 0; i < 16; i++)
      send(i[0], 16'($urandom), $sformatf("rnd_a%0d", i), 1'b0, 16'h0000);
    for (int a = 0; a < 5; a++) wr_coef(5'(a), 16'($urandom_range(0, 16'h7FFF)) - 16'h4000);
    commit_idle();
    for (int i = 0; i < 12; i++)
      send(i[0], 16'($urandom), $sformatf("rnd_b%0d", i), 1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
